// File: rtl/sram_audio_arbiter.sv
// rtl/sram_audio_arbiter.sv - record/playback arbiter owning the 256Kx16 audio SRAM
//
// Purpose: sequences IDLE/RECORD/PLAY from single-cycle commands, moves ADC samples
// into the SRAM and SRAM samples out to the DAC with a fixed two-cycle access, and
// tracks write/read pointers plus the recorded length. Clock domain: codec bclk.
//
// Optional feature macro: LOOP_PLAY_EN (playback wraps at rec_len instead of ending).
//
// Ports:
//   bclk, rst_n                      clock, asynchronous active-low reset
//   cmd_record/cmd_play/cmd_stop     single-cycle command pulses
//   adc_valid/adc_data/adc_ready     capture sample handshake
//   dac_req/dac_data/dac_valid       playback request and one-cycle data strobe
//   sram_addr/sram_dq_o/sram_dq_oe   SRAM address, write data and dq drive enable
//   sram_dq_i                        SRAM read data
//   sram_we_n/sram_oe_n              active-low SRAM strobes
//   state                            0=IDLE, 1=RECORD, 2=PLAY
//   rec_len                          samples held by the last recording
//   done                             one-cycle pulse on any RECORD/PLAY exit
module sram_audio_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              bclk,
    input  logic              rst_n,
    input  logic              cmd_record,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_ready,
    input  logic              dac_req,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   rec_len,
    output logic              done
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RECORD = 2'd1, ST_PLAY = 2'd2} state_e;
    typedef enum logic [1:0] {ENG_IDLE = 2'd0, ENG_WRITE = 2'd1, ENG_READ = 2'd2} eng_e;

    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_MAX  = '1;
    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    eng_e                eng_q, eng_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     rec_len_q, rec_len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dq_o_q, dq_o_d, dac_data_q, dac_data_d;
    logic                dq_oe_q, dq_oe_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic                adc_ready_q, adc_ready_d, dac_valid_q, dac_valid_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     rd_next;

    assign rd_next = {1'b0, rd_ptr_q} + LEN_ONE;

    always_comb begin
        state_d     = state_q;
        eng_d       = ENG_IDLE;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rec_len_d   = rec_len_q;
        addr_d      = addr_q;
        dq_o_d      = dq_o_q;
        dac_data_d  = dac_data_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        dac_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // cmd_stop has no meaning in IDLE, so record wins even if stop is also high.
                if (cmd_record) begin
                    wr_ptr_d  = '0;
                    rec_len_d = '0;
                    state_d   = ST_RECORD;
                end else if (cmd_play && rec_len_q != '0) begin
                    rd_ptr_d = '0;
                    state_d  = ST_PLAY;
                end
            end
            ST_RECORD: begin
                if (eng_q == ENG_WRITE) begin
                    // Completion edge: the in-flight write is always counted, even on stop.
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (wr_ptr_q == PTR_MAX) begin
                        rec_len_d = LEN_FULL;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        rec_len_d = rec_len_q + LEN_ONE;
                        if (cmd_stop) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end else if (cmd_stop) begin
                    // A sample offered on the stop edge is refused.
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (adc_valid && adc_ready_q) begin
                    eng_d   = ENG_WRITE;
                    addr_d  = wr_ptr_q;
                    dq_o_d  = adc_data;
                    we_n_d  = 1'b0;
                    dq_oe_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (eng_q == ENG_READ) begin
                    dac_data_d  = sram_dq_i;
                    dac_valid_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + PTR_ONE;
                    if (rd_next == rec_len_q) begin
`ifdef LOOP_PLAY_EN
                        rd_ptr_d = '0;
`else
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
`endif
                    end
                    if (cmd_stop) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (cmd_stop) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (dac_req) begin
                    eng_d  = ENG_READ;
                    addr_d = rd_ptr_q;
                    oe_n_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Ready is registered: it reflects whether the next edge may accept a sample.
        adc_ready_d = (state_d == ST_RECORD) && (eng_d == ENG_IDLE);
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            eng_q       <= ENG_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rec_len_q   <= '0;
            addr_q      <= '0;
            dq_o_q      <= '0;
            dac_data_q  <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            adc_ready_q <= 1'b0;
            dac_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            eng_q       <= eng_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rec_len_q   <= rec_len_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            dac_data_q  <= dac_data_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            adc_ready_q <= adc_ready_d;
            dac_valid_q <= dac_valid_d;
            done_q      <= done_d;
        end
    end

    assign state      = state_q;
    assign rec_len    = rec_len_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = oe_n_q;
    assign adc_ready  = adc_ready_q;
    assign dac_data   = dac_data_q;
    assign dac_valid  = dac_valid_q;
    assign done       = done_q;

endmodule
